state_ctrl_array: RTL and testbench
===================================

Name: state_ctrl_array

Overview:
Multi-channel successor to the single-channel enable toggle controller. Each channel takes a raw, bouncy push-button or switch level, synchronises it and debounces it. It then drives an enable output in one of four per-channel modes: toggle, momentary, pulse or hold. Sits between board buttons and datapath enables, all on the controller clock.

Parameters:
CHANNELS, 4, number of independent channels (1..32).
DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a level change (>=1).
SRC_ACTIVE_LOW, 1, 1: src=0 means pressed; 0: src=1 means pressed.
RESET_VAL, 1, value loaded into every enable bit on reset and on clr.

Ports:
clk_ctrl  input  1  controller clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
src  input  CHANNELS  raw button/switch levels, asynchronous to clk_ctrl.
mode  input  2*CHANNELS  per-channel mode; bits [2i+1:2i] for channel i: 00 toggle, 01 momentary, 10 pulse, 11 hold.
clr  input  1  synchronous clear of all enables.
enable  output  CHANNELS  controlled enable per channel.
pressed  output  CHANNELS  debounced pressed level, active-high regardless of SRC_ACTIVE_LOW.
press_pulse  output  CHANNELS  one-cycle strobe on each accepted press (released->pressed).

Behaviour:
- Reset (async, while high): enable = {CHANNELS{RESET_VAL}}; pressed = 0; press_pulse = 0. Synchroniser flops hold the released level. Debounce counters = 0.
- Synchroniser: two flops per channel. The raw level, normalised to active-high, is sampled at edge k and visible in stage 2 after edge k+1.
- Debounce, per channel:
  - When stage 2 equals pressed, the counter clears to 0.
  - Otherwise the counter increments each edge.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and stage 2 still differs, pressed <= stage 2 and the counter <= 0.
  - Counter width is clog2(DEBOUNCE_CYCLES); it never wraps.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes pressed.
- Accept event: pressed goes 0->1 at edge k+1+DEBOUNCE_CYCLES, for a level stable from edge k.
  - press_pulse is high for exactly the following cycle (registered at that same edge).
  - Release events set no strobe.
- Enable update, same edge as the accept event, per mode:
  - 00 toggle: enable <= ~enable on press; unchanged otherwise.
  - 01 momentary: enable <= next value of pressed every edge; it follows debounced presses and releases with zero extra latency.
  - 10 pulse: enable <= 1 for exactly one cycle on press, else 0.
  - 11 hold: enable keeps its value; presses still update pressed and press_pulse.
- Mode is sampled every edge with no latching.
  - Changing into momentary or pulse forces enable to the mode's value at the next edge.
  - Changing into toggle or hold keeps the current enable.
- clr high at an edge: all enable bits <= RESET_VAL. This has priority over any press or mode effect in that cycle. pressed and press_pulse are unaffected.
- Channels are fully independent. Simultaneous presses on several channels are all honoured in the same cycle.
- A reset asserted mid-debounce discards partial counts. After release, a press held throughout still needs the full 2+DEBOUNCE_CYCLES latency.
- No combinational path from any input to any output.

Test Plan:
1. Reset release, CHANNELS=4, RESET_VAL=1, src=4'hF (released, active-low) -> enable=4'hF, pressed=0, press_pulse=0 for 50 cycles.
2. DEBOUNCE_CYCLES=4, mode=toggle, src[0] 1->0 sampled at edge k and held -> pressed[0]=1 and enable[0]=0 after edge k+5; press_pulse[0]=1 for exactly that cycle; a second press and release -> enable[0]=1.
3. DEBOUNCE_CYCLES=4, src[1] low for 3 cycles then high -> pressed[1], press_pulse[1] and enable[1] unchanged.
4. ch2 in momentary: hold press 20 cycles -> enable[2] goes 1 with pressed[2], returns 0 with pressed[2] on release. ch3 in pulse: one press -> enable[3]=1 for one cycle only.
5. Press ch0 and ch1 accepted on the same edge with clr=1 on that edge -> enable=RESET_VAL on both; press_pulse=2'b11 still seen. Next press toggles normally.
6. Assert reset while the ch0 counter is at 2 of 4, release after 3 cycles with src[0] still low -> enable[0]=1. It toggles only 6 edges after reset release.

Source files
------------

// File: rtl/state_ctrl_array_if.sv
// Bus bundle for state_ctrl_array.
//   src         raw button/switch levels (asynchronous to the controller clock)
//   mode        per-channel mode, bits [2i+1:2i] for channel i
//   clr         synchronous clear of all enables
//   enable      controlled enable per channel
//   pressed     debounced pressed level, active-high
//   press_pulse one-cycle strobe on each accepted press
// master drives the inputs of the block; slave is the block itself.
interface state_ctrl_array_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0]   src;
  logic [2*CHANNELS-1:0] mode;
  logic                  clr;
  logic [CHANNELS-1:0]   enable;
  logic [CHANNELS-1:0]   pressed;
  logic [CHANNELS-1:0]   press_pulse;

  modport master (
    output src, mode, clr,
    input  enable, pressed, press_pulse
  );

  modport slave (
    input  src, mode, clr,
    output enable, pressed, press_pulse
  );
endinterface

// File: rtl/state_ctrl_array.sv
// Multi-channel button conditioner and enable controller.
// Each channel synchronises a raw button level (two flops), debounces it
// (DEBOUNCE_CYCLES consecutive differing cycles accept a change) and drives
// its enable in one of four modes: toggle, momentary, pulse or hold.
// Ports:
//   clk_ctrl  controller clock, all state on the rising edge
//   reset     asynchronous active-high reset
//   bus       state_ctrl_array_if.slave (src, mode, clr in; enable,
//             pressed, press_pulse out). All outputs come straight from flops.
module state_ctrl_array #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter bit          SRC_ACTIVE_LOW  = 1'b1,
  parameter bit          RESET_VAL       = 1'b1
) (
  input logic               clk_ctrl,
  input logic               reset,
  state_ctrl_array_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_TOGGLE    = 2'b00,
    MODE_MOMENTARY = 2'b01,
    MODE_PULSE     = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

  // A single-cycle debounce still needs one counter bit to keep the
  // counter arithmetic well formed; it simply never leaves zero.
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;
  logic [CHANNELS-1:0] pressed_q, pressed_d;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] enable_q, enable_d;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];

  always_comb begin
    // Normalise to active-high before the synchroniser so the released
    // level is always 0 inside the block.
    sync1_d   = SRC_ACTIVE_LOW ? ~bus.src : bus.src;
    sync2_d   = sync1_q;
    pressed_d = pressed_q;
    pulse_d   = '0;
    enable_d  = enable_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != pressed_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          pressed_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
      pulse_d[i] = pressed_d[i] & ~pressed_q[i];

      // Enable follows the next-state pressed/press strobe so that it moves
      // on the same edge as the accept event.
      case (mode_e'(bus.mode[2*i +: 2]))
        MODE_TOGGLE:    enable_d[i] = enable_q[i] ^ pulse_d[i];
        MODE_MOMENTARY: enable_d[i] = pressed_d[i];
        MODE_PULSE:     enable_d[i] = pulse_d[i];
        default:        enable_d[i] = enable_q[i];
      endcase
    end
    if (bus.clr) begin
      enable_d = {CHANNELS{RESET_VAL}};
    end
  end

  always_ff @(posedge clk_ctrl or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pressed_q <= '0;
      pulse_q   <= '0;
      enable_q  <= {CHANNELS{RESET_VAL}};
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      pressed_q <= pressed_d;
      pulse_q   <= pulse_d;
      enable_q  <= enable_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.enable      = enable_q;
  assign bus.pressed     = pressed_q;
  assign bus.press_pulse = pulse_q;

endmodule

// File: tb/tb_state_ctrl_array.sv
module tb_state_ctrl_array;
  localparam int unsigned CH = 4;
  localparam int unsigned D  = 4;
  localparam bit          RV = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  state_ctrl_array_if #(.CHANNELS(CH)) bus ();

  state_ctrl_array #(
    .CHANNELS(CH),
    .DEBOUNCE_CYCLES(D),
    .SRC_ACTIVE_LOW(1'b1),
    .RESET_VAL(RV)
  ) dut (
    .clk_ctrl(clk),
    .reset(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [CH-1:0] en;
    logic [CH-1:0] pr;
    logic [CH-1:0] pp;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_n   = 0;

  // Reference model: a sliding window of the last D+2 sampled
  // (active-high) levels. A level sampled at edge e reaches the debouncer
  // two edges later, so at edge e the D oldest entries (edges e-1-D..e-2)
  // decide: if they all differ from the current pressed level, it flips.
  logic [CH-1:0] m_en, m_pr;
  logic [CH-1:0] hist[$];

  logic [CH-1:0]   cur_s;
  logic [2*CH-1:0] cur_m;

  task automatic model_reset();
    m_en = {CH{RV}};
    m_pr = '0;
    hist.delete();
    for (int i = 0; i < int'(D) + 2; i++) hist.push_back('0);
  endtask

  task automatic model_edge(input logic [CH-1:0] s, input logic [2*CH-1:0] m,
                            input logic c, output exp_t e);
    logic [CH-1:0] pp;
    pp = '0;
    hist.push_back(~s);
    void'(hist.pop_front());
    for (int ch = 0; ch < int'(CH); ch++) begin
      bit all_diff;
      bit new_pr;
      bit acc;
      all_diff = 1'b1;
      for (int i = 0; i < int'(D); i++)
        if (hist[i][ch] == m_pr[ch]) all_diff = 1'b0;
      new_pr = all_diff ? ~m_pr[ch] : m_pr[ch];
      acc    = all_diff && new_pr;
      case (m[2*ch +: 2])
        2'b00: m_en[ch] = m_en[ch] ^ acc;
        2'b01: m_en[ch] = new_pr;
        2'b10: m_en[ch] = acc;
        default: ;
      endcase
      if (c) m_en[ch] = RV;
      pp[ch]   = acc;
      m_pr[ch] = new_pr;
    end
    e = '{en: m_en, pr: m_pr, pp: pp};
  endtask

  // One controller cycle: drive inputs at the falling edge and queue what
  // the outputs must show after the following rising edge.
  task automatic cyc(input logic [CH-1:0] s, input logic [2*CH-1:0] m,
                     input logic c, input logic r);
    exp_t e;
    @(negedge clk);
    bus.src  = s;
    bus.mode = m;
    bus.clr  = c;
    rst      = r;
    cur_s    = s;
    cur_m    = m;
    if (r) begin
      model_reset();
      e = '{en: m_en, pr: m_pr, pp: '0};
    end else begin
      model_edge(s, m, c, e);
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [CH-1:0] s, input int n);
    for (int i = 0; i < n; i++) cyc(s, cur_m, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, act, req);
    end
  endtask

  // Monitor: every rising edge presents a fresh output set.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("enable", bus.enable, e.en);
        check("pressed", bus.pressed, e.pr);
        check("press_pulse", bus.press_pulse, e.pp);
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [CH-1:0]   s;
    logic [2*CH-1:0] m;
    logic            c;
    logic            r;
    int              rem [CH];
    int              rst_left;

    bus.src  = '1;
    bus.mode = '0;
    bus.clr  = 1'b0;
    cur_s    = '1;
    cur_m    = '0;
    model_reset();

    // Reset and idle with everything released.
    repeat (3) cyc(4'hF, 8'h00, 1'b0, 1'b1);
    hold(4'hF, 50);

    // Toggle on ch0: press, release, press, release.
    hold(4'hE, 8); hold(4'hF, 8);
    hold(4'hE, 8); hold(4'hF, 8);

    // Glitch on ch1 shorter than the debounce window.
    hold(4'hD, 3); hold(4'hF, 10);

    // ch2 momentary, ch3 pulse.
    cyc(4'hF, 8'b10_01_00_00, 1'b0, 1'b0);
    hold(4'hF, 3);
    hold(4'hB, 20); hold(4'hF, 10);
    hold(4'h7, 8);  hold(4'hF, 10);

    // ch0+ch1 accepted on the edge where clr is high.
    cyc(4'hF, 8'h00, 1'b0, 1'b0);
    hold(4'hC, 5);
    cyc(4'hC, 8'h00, 1'b1, 1'b0);
    hold(4'hC, 4); hold(4'hF, 8);
    hold(4'hC, 8); hold(4'hF, 8);

    // Reset in the middle of a debounce, press held throughout.
    hold(4'hE, 4);
    repeat (3) cyc(4'hE, 8'h00, 1'b0, 1'b1);
    hold(4'hE, 10); hold(4'hF, 8);

    // Randomised phase: bouncy levels, mode changes, clears, resets.
    s = 4'hF;
    m = 8'h00;
    rst_left = 0;
    for (int ch = 0; ch < int'(CH); ch++) rem[ch] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int ch = 0; ch < int'(CH); ch++) begin
        if (rem[ch] == 0) begin
          s[ch]   = 1'($urandom_range(0, 1));
          rem[ch] = $urandom_range(1, 12);
        end
        rem[ch]--;
      end
      if ($urandom_range(0, 49) == 0) m = 8'($urandom);
      c = ($urandom_range(0, 39) == 0);
      r = 1'b0;
      if (rst_left > 0) begin
        rst_left--;
        r = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        rst_left = $urandom_range(0, 2);
        r = 1'b1;
      end
      cyc(s, m, c, r);
    end
    hold(4'hF, 12);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
